uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx.sv | 158 +++++++++++++++
 tb/tb_uart_rx.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Consumer-side handshake of the UART receiver: holding register, pop strobe and sticky error flags.
`timescale 1ns/1ps
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rd_en;
   logic       err_clr;
   logic       frame_err;
   logic       parity_err;
   logic       overrun_err;

   modport master (
      output rx_data, rx_valid, frame_err, parity_err, overrun_err,
      input  rd_en, err_clr
   );

   modport slave (
      input  rx_data, rx_valid, frame_err, parity_err, overrun_err,
      output rd_en, err_clr
   );
endinterface

// File: rtl/uart_rx.sv
// Oversampled UART receiver with single-byte holding register and sticky error flags.
// Define UART_RX_PARITY_EN to compile in the PARITY state and csr[1:0] parity decoding.
`timescale 1ns/1ps
module uart_rx #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] csr,
   input  logic        tick_rx,
   input  logic        rx,
   output logic        busy,
   uart_rx_if.master   bus
);
   // state  | meaning
   // IDLE   | line idle, waiting for rx=0
   // START  | timing to mid start bit, rejecting glitches
   // DATA   | sampling DATA_BITS bits LSB first
   // PARITY | sampling and checking the parity bit
   // STOP   | sampling stop bit, loading holding register
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

   state_t                 state;
   logic                   rx_s1;
   logic                   rx_s2;
   logic [TW-1:0]          tick_cnt;
   logic [TW-1:0]          tick_nxt;
   logic [2:0]             bit_cnt;
   logic [DATA_BITS-1:0]   shift;
   logic [7:0]             shift_ext;
   logic                   sample;

`ifdef UART_RX_PARITY_EN
   logic par_en;
   logic par_odd;
   logic unused_csr;
   assign unused_csr = ^csr[31:2];
`else
   logic unused_csr;
   assign unused_csr = ^csr;
   assign bus.parity_err = 1'b0;
`endif

   assign busy     = (state != IDLE);
   assign tick_nxt = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
   assign sample   = tick_rx && (tick_cnt == TICK_LAST);

   always_comb begin
      shift_ext = '0;
      shift_ext[DATA_BITS-1:0] = shift;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         rx_s1           <= 1'b1;
         rx_s2           <= 1'b1;
         tick_cnt        <= '0;
         bit_cnt         <= '0;
         shift           <= '0;
         bus.rx_data     <= '0;
         bus.rx_valid    <= 1'b0;
         bus.frame_err   <= 1'b0;
         bus.overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         bus.parity_err  <= 1'b0;
         par_en          <= 1'b0;
         par_odd         <= 1'b0;
`endif
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;

         if (bus.rd_en && bus.rx_valid)
            bus.rx_valid <= 1'b0;

         // Error sets below are written later in this block, so a coincident set beats err_clr.
         if (bus.err_clr) begin
            bus.frame_err   <= 1'b0;
            bus.overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            bus.parity_err  <= 1'b0;
`endif
         end

         case (state)
            IDLE: begin
               if (!rx_s2) begin
                  state    <= START;
                  tick_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                  par_en   <= csr[0];
                  par_odd  <= csr[1];
`endif
               end
            end
            START: begin
               if (tick_rx) begin
                  if (tick_cnt == TICK_MID) begin
                     tick_cnt <= '0;
                     bit_cnt  <= '0;
                     state    <= rx_s2 ? IDLE : DATA;
                  end else begin
                     tick_cnt <= tick_nxt;
                  end
               end
            end
            DATA: begin
               if (tick_rx)
                  tick_cnt <= tick_nxt;
               if (sample) begin
                  shift <= {rx_s2, shift[DATA_BITS-1:1]};
                  if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state <= par_en ? PARITY : STOP;
`else
                     state <= STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick_rx)
                  tick_cnt <= tick_nxt;
               if (sample) begin
                  if (((^shift) ^ rx_s2) != par_odd)
                     bus.parity_err <= 1'b1;
                  state <= STOP;
               end
            end
`endif
            STOP: begin
               if (tick_rx)
                  tick_cnt <= tick_nxt;
               if (sample) begin
                  if (!rx_s2)
                     bus.frame_err <= 1'b1;
                  if (bus.rx_valid && !bus.rd_en)
                     bus.overrun_err <= 1'b1;
                  bus.rx_data  <= shift_ext;
                  bus.rx_valid <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at OVERSAMPLE=16, 8 data bits; one tick_rx every 4 clk.
`timescale 1ns/1ps
module tb_uart_rx;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] csr = '0;
   logic        tick_rx = 1'b0;
   logic        rx = 1'b1;
   logic        busy;
   int          checks = 0;
   int          failures = 0;
   int          busy_ticks;

   uart_rx_if bus_if ();

   uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .csr     (csr),
      .tick_rx (tick_rx),
      .rx      (rx),
      .busy    (busy),
      .bus     (bus_if.master)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         repeat (3) @(negedge clk);
         tick_rx = 1'b1;
         @(negedge clk);
         tick_rx = 1'b0;
      end
   endtask

   // Returns with the stop-sample tick raised but not yet clocked.
   task automatic send_frame(input logic [7:0] d, input bit use_par, input logic par_bit,
                             input logic stop_bit);
      rx = 1'b0;
      ticks(16);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         ticks(16);
      end
      if (use_par) begin
         rx = par_bit;
         ticks(16);
      end
      rx = stop_bit;
      ticks(7);
      repeat (3) @(negedge clk);
      tick_rx = 1'b1;
   endtask

   task automatic finish_frame();
      @(negedge clk);
      tick_rx = 1'b0;
      rx = 1'b1;
      bus_if.rd_en = 1'b0;
      bus_if.err_clr = 1'b0;
   endtask

   task automatic pulse_rd_clr(input logic rd, input logic clr);
      @(negedge clk);
      bus_if.rd_en = rd;
      bus_if.err_clr = clr;
      @(negedge clk);
      bus_if.rd_en = 1'b0;
      bus_if.err_clr = 1'b0;
   endtask

   initial begin
      bus_if.rd_en = 1'b0;
      bus_if.err_clr = 1'b0;
      #1;
      check("rst_rx_data", 32'(bus_if.rx_data), 32'h0);
      check("rst_rx_valid", 32'(bus_if.rx_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_flags", 32'({bus_if.frame_err, bus_if.parity_err, bus_if.overrun_err}), 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      ticks(4);

      // 8N1 0xA5, one clk from stop-sample tick to rx_valid
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      check("a5_valid_before_edge", 32'(bus_if.rx_valid), 32'h0);
      finish_frame();
      check("a5_rx_data", 32'(bus_if.rx_data), 32'hA5);
      check("a5_rx_valid", 32'(bus_if.rx_valid), 32'h1);
      check("a5_flags", 32'({bus_if.frame_err, bus_if.parity_err, bus_if.overrun_err}), 32'h0);
      check("a5_busy", 32'(busy), 32'h0);
      ticks(8);
      pulse_rd_clr(1'b1, 1'b0);
      check("a5_pop", 32'(bus_if.rx_valid), 32'h0);
      pulse_rd_clr(1'b1, 1'b0);
      check("pop_empty_ignored", 32'(bus_if.rx_valid), 32'h0);

      // false start: low for 4 ticks
      rx = 1'b0;
      ticks(4);
      check("false_start_busy", 32'(busy), 32'h1);
      rx = 1'b1;
      busy_ticks = 4;
      for (int i = 0; i < 20; i++) begin
         if (busy) begin
            ticks(1);
            busy_ticks++;
         end
      end
      check("false_start_idle", 32'(busy), 32'h0);
      check("false_start_len_le8", 32'(busy_ticks <= 8), 32'h1);
      check("false_start_valid", 32'(bus_if.rx_valid), 32'h0);
      check("false_start_flags", 32'({bus_if.frame_err, bus_if.parity_err, bus_if.overrun_err}), 32'h0);

      // 0x3C with stop=0, err_clr coinciding with the error: set wins
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      bus_if.err_clr = 1'b1;
      finish_frame();
      check("3c_rx_data", 32'(bus_if.rx_data), 32'h3C);
      check("3c_rx_valid", 32'(bus_if.rx_valid), 32'h1);
      check("3c_frame_err_set_wins", 32'(bus_if.frame_err), 32'h1);
      ticks(12);
      check("3c_frame_err_sticky", 32'(bus_if.frame_err), 32'h1);
      pulse_rd_clr(1'b1, 1'b1);
      check("3c_frame_err_cleared", 32'(bus_if.frame_err), 32'h0);
      check("3c_popped", 32'(bus_if.rx_valid), 32'h0);

      // overrun: 0x11 then 0x22 unread
      send_frame(8'h11, 1'b0, 1'b0, 1'b1);
      finish_frame();
      ticks(8);
      check("ovr_no_err_first", 32'(bus_if.overrun_err), 32'h0);
      send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      finish_frame();
      check("ovr_rx_data", 32'(bus_if.rx_data), 32'h22);
      check("ovr_rx_valid", 32'(bus_if.rx_valid), 32'h1);
      check("ovr_overrun_err", 32'(bus_if.overrun_err), 32'h1);
      ticks(8);
      pulse_rd_clr(1'b1, 1'b1);
      check("ovr_cleared", 32'(bus_if.overrun_err), 32'h0);

      // repeat, with rd_en on the completion cycle of 0x22
      send_frame(8'h11, 1'b0, 1'b0, 1'b1);
      finish_frame();
      ticks(8);
      send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      bus_if.rd_en = 1'b1;
      finish_frame();
      check("rd_same_cycle_data", 32'(bus_if.rx_data), 32'h22);
      check("rd_same_cycle_valid", 32'(bus_if.rx_valid), 32'h1);
      check("rd_same_cycle_no_ovr", 32'(bus_if.overrun_err), 32'h0);
      ticks(8);

`ifdef UART_RX_PARITY_EN
      pulse_rd_clr(1'b1, 1'b1);
      // odd parity, 0x07 has three ones: parity bit 0 makes the total odd
      csr = 32'h3;
      send_frame(8'h07, 1'b1, 1'b1, 1'b1);
      csr = 32'h0;
      finish_frame();
      check("par_bad_data", 32'(bus_if.rx_data), 32'h07);
      check("par_bad_err", 32'(bus_if.parity_err), 32'h1);
      ticks(8);
      pulse_rd_clr(1'b1, 1'b1);
      csr = 32'h3;
      send_frame(8'h07, 1'b1, 1'b0, 1'b1);
      finish_frame();
      check("par_good_err", 32'(bus_if.parity_err), 32'h0);
      check("par_good_frame", 32'(bus_if.frame_err), 32'h0);
      csr = 32'h0;
      ticks(8);
`else
      // parity disabled: csr[1:0] ignored, no parity bit on the line
      pulse_rd_clr(1'b1, 1'b1);
      csr = 32'h3;
      send_frame(8'h07, 1'b0, 1'b0, 1'b1);
      finish_frame();
      check("nopar_data", 32'(bus_if.rx_data), 32'h07);
      check("nopar_parity_err", 32'(bus_if.parity_err), 32'h0);
      check("nopar_frame_err", 32'(bus_if.frame_err), 32'h0);
      csr = 32'h0;
      ticks(8);
`endif

      // 0xFF interrupted in data bit 3; tick_rx held low must freeze the FSM
      check("pre_rst_valid", 32'(bus_if.rx_valid), 32'h1);
      rx = 1'b0;
      ticks(16);
      for (int i = 0; i < 3; i++) begin
         rx = 1'b1;
         ticks(16);
      end
      ticks(8);
      repeat (40) @(negedge clk);
      check("tick_hold_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      #1;
      check("mid_rst_rx_data", 32'(bus_if.rx_data), 32'h0);
      check("mid_rst_rx_valid", 32'(bus_if.rx_valid), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_flags", 32'({bus_if.frame_err, bus_if.parity_err, bus_if.overrun_err}), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      ticks(20);
      check("post_rst_idle", 32'(busy), 32'h0);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      finish_frame();
      check("post_rst_5a_data", 32'(bus_if.rx_data), 32'h5A);
      check("post_rst_5a_valid", 32'(bus_if.rx_valid), 32'h1);
      check("post_rst_5a_flags", 32'({bus_if.frame_err, bus_if.parity_err, bus_if.overrun_err}), 32'h0);
      ticks(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
